display_scan_ctrl: RTL and testbench

- Time-multiplexes one shared 7-segment digit decoder across N common-anode digits of the digital clock display.
- Each scan slot selects one digit nibble, drives it to the decoder's 4-bit show-code input and enables that digit's anode (active-low).
- Inserts a blanking gap between digits to prevent ghosting.
- Supports per-digit blinking for time-set mode and per-digit decimal points.
- Sits between the time/alarm registers and the decoder plus board pins.

---
 rtl/display_scan_ctrl.sv | 142 ++++++++++++++
 tb/tb_display_scan_ctrl.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for N common-anode 7-segment digits sharing one decoder.
// Alternates a BLANK gap and a SHOW slot per digit, with per-digit blink and decimal point.
module display_scan_ctrl #(
  parameter int unsigned N_DIG        = 8,
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLANK_CYC    = 500,
  parameter int unsigned BLINK_FRAMES = 250
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [4*N_DIG-1:0] digits,
  input  logic [N_DIG-1:0]   blink_mask,
  input  logic [N_DIG-1:0]   dp_mask,
  output logic [3:0]         show_code,
  output logic [N_DIG-1:0]   an,
  output logic               dp_n,
  output logic               frame_done
);

  localparam int unsigned CntMax = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned IdxW   = $clog2(N_DIG);
  localparam int unsigned FrmW   = $clog2(BLINK_FRAMES + 1);

  localparam logic [0:0] StBlank = 1'b0;
  localparam logic [0:0] StShow  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [FrmW-1:0]  frm_q, frm_d;
  logic             phase_q, phase_d;
  logic [N_DIG-1:0] an_q, an_d;
  logic [3:0]       code_q, code_d;
  logic             dp_n_q, dp_n_d;
  logic             fd_q, fd_d;

  logic [3:0]       cur_nib;
  logic [N_DIG-1:0] one_hot;

  assign cur_nib = digits[{idx_q, 2'b00} +: 4];
  assign one_hot = N_DIG'(1) << idx_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    frm_d   = frm_q;
    phase_d = phase_q;
    an_d    = an_q;
    code_d  = code_q;
    dp_n_d  = dp_n_q;
    fd_d    = 1'b0;

    if (!en) begin
      state_d = StBlank;
      cnt_d   = '0;
      idx_d   = '0;
      an_d    = '1;
      code_d  = 4'hF;
      dp_n_d  = 1'b1;
    end else begin
      unique case (state_q)
        StBlank: begin
          // cnt counts blank cycles already presented; 0 after reset/disable adds a lead-in cycle
          if (cnt_q == CntW'(BLANK_CYC)) begin
            state_d = StShow;
            cnt_d   = CntW'(1);
            an_d    = ~one_hot;
            if (phase_q && blink_mask[idx_q]) begin
              code_d = 4'hF;
              dp_n_d = 1'b1;
            end else begin
              code_d = cur_nib;
              dp_n_d = ~dp_mask[idx_q];
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StShow: begin
          if (cnt_q == CntW'(SCAN_DIV)) begin
            state_d = StBlank;
            cnt_d   = CntW'(1);
            an_d    = '1;
            code_d  = 4'hF;
            dp_n_d  = 1'b1;
            if (idx_q == IdxW'(N_DIG - 1)) begin
              idx_d = '0;
              fd_d  = 1'b1;
              if (frm_q == FrmW'(BLINK_FRAMES - 1)) begin
                frm_d   = '0;
                phase_d = ~phase_q;
              end else begin
                frm_d = frm_q + FrmW'(1);
              end
            end else begin
              idx_d = idx_q + IdxW'(1);
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        default: begin
          state_d = StBlank;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StBlank;
      cnt_q   <= '0;
      idx_q   <= '0;
      frm_q   <= '0;
      phase_q <= 1'b0;
      an_q    <= '1;
      code_q  <= 4'hF;
      dp_n_q  <= 1'b1;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      frm_q   <= frm_d;
      phase_q <= phase_d;
      an_q    <= an_d;
      code_q  <= code_d;
      dp_n_q  <= dp_n_d;
      fd_q    <= fd_d;
    end
  end

  assign show_code  = code_q;
  assign an         = an_q;
  assign dp_n       = dp_n_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl: the driver queues the expected outputs of each
// upcoming edge, a monitor pops and compares one record per clock.
module tb_display_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [31:0] digits = '0;
  logic [7:0]  blink_mask = '0;
  logic [7:0]  dp_mask = '0;
  logic [3:0]  show_code;
  logic [7:0]  an;
  logic        dp_n;
  logic        frame_done;

  display_scan_ctrl #(
    .N_DIG(8), .SCAN_DIV(4), .BLANK_CYC(1), .BLINK_FRAMES(2)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .digits(digits), .blink_mask(blink_mask),
    .dp_mask(dp_mask), .show_code(show_code), .an(an), .dp_n(dp_n), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] an;
    logic [3:0] code;
    logic       dp_n;
    logic       fd;
  } exp_t;

  localparam exp_t BlankExp = '{an: 8'hFF, code: 4'hF, dp_n: 1'b1, fd: 1'b0};

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   mon_cyc  = 0;

  // Expected outputs at cycle c of an uninterrupted scan (slot = 1 blank + 4 show cycles).
  function automatic exp_t model(int c, logic [31:0] dig, logic [7:0] bm, logic [7:0] dpm);
    exp_t        e;
    int          pos, k, frame;
    logic [31:0] d;
    logic [7:0]  one;
    pos   = c % 5;
    k     = (c / 5) % 8;
    frame = c / 40;
    one   = 8'h01;
    e     = BlankExp;
    if (pos == 0) begin
      e.fd = (c >= 40) && (c % 40 == 0);
    end else begin
      e.an = ~(one << k);
      d    = dig >> (4 * k);
      if (((frame / 2) % 2 == 1) && bm[k]) begin
        e.code = 4'hF;
        e.dp_n = 1'b1;
      end else begin
        e.code = d[3:0];
        e.dp_n = ~dpm[k];
      end
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s mon_cyc=%0d t=%0t actual=%h required=%h", name, mon_cyc, $time, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("an", an, e.an);
        chk("show_code", {4'h0, show_code}, {4'h0, e.code});
        chk("dp_n", {7'h0, dp_n}, {7'h0, e.dp_n});
        chk("frame_done", {7'h0, frame_done}, {7'h0, e.fd});
        mon_cyc++;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b1;
    sb_q.push_back(BlankExp);
  endtask

  initial begin : driver
    // Basic scan, no tearing on digit 0, decimal point on digit 2
    digits = 32'h7654_3210; blink_mask = 8'h00; dp_mask = 8'h04;
    do_reset();
    for (int c = 0; c < 88; c++) begin
      @(negedge clk);
      rst = 1'b0;
      if (c == 2) digits[3:0] = 4'h9;
      sb_q.push_back(model(c, (c < 40) ? 32'h7654_3210 : 32'h7654_3219, 8'h00, 8'h04));
    end

    // Blink on digits 0 and 2 (digit 2 also has dp), then reset during digit 5 in phase 1
    digits = 32'hCBA9_8765; blink_mask = 8'h05; dp_mask = 8'h04;
    do_reset();
    for (int c = 0; c < 107; c++) begin
      @(negedge clk);
      rst = 1'b0;
      sb_q.push_back(model(c, 32'hCBA9_8765, 8'h05, 8'h04));
    end
    do_reset();
    for (int c = 0; c < 170; c++) begin
      @(negedge clk);
      rst = 1'b0;
      sb_q.push_back(model(c, 32'hCBA9_8765, 8'h05, 8'h04));
    end

    // Enable dropped for 3 cycles while digit 2 is showing
    digits = 32'h7654_3210; blink_mask = 8'h00; dp_mask = 8'h00;
    do_reset();
    for (int c = 0; c < 61; c++) begin
      @(negedge clk);
      rst = 1'b0;
      if (c >= 12 && c <= 14) begin
        en = 1'b0;
        sb_q.push_back(BlankExp);
      end else begin
        en = 1'b1;
        sb_q.push_back(model((c < 12) ? c : c - 15, 32'h7654_3210, 8'h00, 8'h00));
      end
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 8'(sb_q.size()), 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
